cheri_stkz_lsu_arb: RTL

- Sits between the core load/store path, the stack-zeroization engine and the data-memory LSU port.
- Arbitrates between core data requests and zeroization write requests, then issues the winner on one LSU request channel.
- Routes in-order responses back to their owner using a small owner FIFO.
- Stalls core accesses that fall inside the live zeroization window, so software never sees stale stack data.

---
 rtl/cheri_stkz_lsu_arb.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cheri_stkz_lsu_arb.sv
// rtl/cheri_stkz_lsu_arb.sv - core / stack-zeroization arbiter onto one LSU port with in-order response routing
module cheri_stkz_lsu_arb #(
    parameter int MAX_OUTST  = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic        core_is_cap_i,
    input  logic [31:0] core_addr_i,
    input  logic [32:0] core_wdata_i,
    output logic        core_gnt_o,
    output logic        core_resp_valid_o,
    output logic        core_resp_err_o,
    output logic [32:0] core_rdata_o,
    input  logic        stkz_lsu_req_i,
    input  logic        stkz_lsu_we_i,
    input  logic        stkz_lsu_is_cap_i,
    input  logic [31:0] stkz_lsu_addr_i,
    input  logic [32:0] stkz_lsu_wdata_i,
    input  logic        stkz_active_i,
    input  logic [31:0] stkz_ptr_i,
    input  logic [31:0] stkz_base_i,
    output logic        lsu_stkz_req_done_o,
    output logic        lsu_stkz_resp_valid_o,
    output logic        lsu_stkz_resp_err_o,
    output logic        lsu_req_o,
    output logic        lsu_we_o,
    output logic        lsu_is_cap_o,
    output logic [31:0] lsu_addr_o,
    output logic [32:0] lsu_wdata_o,
    input  logic        lsu_gnt_i,
    input  logic        lsu_resp_valid_i,
    input  logic        lsu_resp_err_i,
    input  logic [32:0] lsu_rdata_i,
    output logic        arb_err_o
);

    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);

    logic [MAX_OUTST-1:0] own_q, own_d;
    logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SW-1:0]        starve_q, starve_d;
    logic                 arb_err_q, arb_err_d;

    logic fifo_full, fifo_empty, hazard, core_ok, stkz_ok;
    logic sel_core, sel_stkz, push, pop, head;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
    endfunction

    // Eligibility and winner selection, with a forced stkz slot once the core has starved it
    always_comb begin
        fifo_full  = (cnt_q == CW'(MAX_OUTST));
        fifo_empty = (cnt_q == '0);
        hazard     = stkz_active_i & core_req_i
                   & (core_addr_i[31:2] >= stkz_base_i[31:2])
                   & (core_addr_i[31:2] <  stkz_ptr_i[31:2]);
        core_ok    = core_req_i & ~hazard & ~fifo_full;
        stkz_ok    = stkz_lsu_req_i & ~fifo_full;
        sel_stkz   = stkz_ok & ((starve_q == SW'(STARVE_LIM)) | ~core_ok);
        sel_core   = core_ok & ~sel_stkz;
    end

    // Request mux toward memory and grant passthrough to the winner
    always_comb begin
        lsu_req_o    = sel_core | sel_stkz;
        lsu_we_o     = 1'b0;
        lsu_is_cap_o = 1'b0;
        lsu_addr_o   = '0;
        lsu_wdata_o  = '0;
        if (sel_core) begin
            lsu_we_o     = core_we_i;
            lsu_is_cap_o = core_is_cap_i;
            lsu_addr_o   = core_addr_i;
            lsu_wdata_o  = core_wdata_i;
        end else if (sel_stkz) begin
            lsu_we_o     = stkz_lsu_we_i;
            lsu_is_cap_o = stkz_lsu_is_cap_i;
            lsu_addr_o   = stkz_lsu_addr_i;
            lsu_wdata_o  = stkz_lsu_wdata_i;
        end
        core_gnt_o          = lsu_gnt_i & lsu_req_o & sel_core;
        lsu_stkz_req_done_o = lsu_gnt_i & lsu_req_o & sel_stkz;
    end

    // Route each response to the owner at the FIFO head; orphan responses are dropped
    always_comb begin
        push                  = lsu_req_o & lsu_gnt_i;
        pop                   = lsu_resp_valid_i & ~fifo_empty;
        head                  = own_q[rptr_q];
        core_resp_valid_o     = pop & ~head;
        core_resp_err_o       = pop & ~head & lsu_resp_err_i;
        core_rdata_o          = (pop & ~head) ? lsu_rdata_i : '0;
        lsu_stkz_resp_valid_o = pop & head;
        lsu_stkz_resp_err_o   = pop & head & lsu_resp_err_i;
        arb_err_o             = arb_err_q;
    end

    // Next-state for owner FIFO, starvation counter and sticky protocol error
    always_comb begin
        own_d  = own_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            own_d[wptr_q] = sel_stkz;
            wptr_d        = next_ptr(wptr_q);
        end
        if (pop) begin
            rptr_d = next_ptr(rptr_q);
        end
        if (push & ~pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop & ~push) begin
            cnt_d = cnt_q - CW'(1);
        end

        starve_d = starve_q;
        if (lsu_stkz_req_done_o | ~stkz_lsu_req_i) begin
            starve_d = '0;
        end else if (core_gnt_o && starve_q != SW'(STARVE_LIM)) begin
            starve_d = starve_q + SW'(1);
        end

        arb_err_d = arb_err_q | (lsu_resp_valid_i & fifo_empty);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            own_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            starve_q  <= '0;
            arb_err_q <= 1'b0;
        end else begin
            own_q     <= own_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            arb_err_q <= arb_err_d;
        end
    end

endmodule
